arm_multicycle_ctrl: RTL and testbench

Control unit for the multicycle ARM core. It decodes the latched instruction fields and sequences the datapath through fetch, decode, execute, memory and writeback states. It produces the `alu_defs` ALUControl codes that the shared ALU consumes. It also owns the NZCV flag register and condition evaluation, and gates every architectural write strobe with the condition result.

---
 rtl/arm_multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: FSM sequencing, ALU command decode,
// NZCV flag register and condition evaluation gating the write strobes.
module arm_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [2:0] alu_control,
  output logic [3:0] flags
);

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR  = 3'b011, ALU_MOV = 3'b100;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t state_q, state_d;

  logic [3:0] cmd;
  logic       i_bit, s_bit;
  assign i_bit = funct[5];
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  // Data-processing decode; unsupported commands act as ADD without writeback
  logic [2:0] dp_alu;
  logic       dp_wb, dp_logic, dp_cmp;
  always_comb begin
    dp_alu   = ALU_ADD;
    dp_wb    = 1'b0;
    dp_logic = 1'b0;
    dp_cmp   = 1'b0;
    case (cmd)
      4'b0100: dp_wb = 1'b1;
      4'b0010: begin dp_alu = ALU_SUB; dp_wb = 1'b1; end
      4'b1010: begin dp_alu = ALU_SUB; dp_cmp = 1'b1; end
      4'b0000: begin dp_alu = ALU_AND; dp_wb = 1'b1; dp_logic = 1'b1; end
      4'b1100: begin dp_alu = ALU_OR;  dp_wb = 1'b1; dp_logic = 1'b1; end
      4'b1101: begin dp_alu = ALU_MOV; dp_wb = 1'b1; dp_logic = 1'b1; end
      default: ;
    endcase
  end

  logic n_f, z_f, c_f, v_f, cond_ex;
  assign {n_f, z_f, c_f, v_f} = flags;
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  logic in_exec;
  assign in_exec = (state_q == EXECR) || (state_q == EXECI);

  // Flags written at the end of execute become visible to ALUWB's condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags <= 4'b0000;
    else if (in_exec && cond_ex && (s_bit || dp_cmp))
      flags <= dp_logic ? {alu_flags[3:2], flags[1:0]} : alu_flags;
  end

  logic pcw_raw, memw_raw, regw_raw, irw_raw;
  always_comb begin
    state_d     = FETCH;
    pcw_raw     = 1'b0;
    memw_raw    = 1'b0;
    regw_raw    = 1'b0;
    irw_raw     = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    imm_src     = 2'b00;
    reg_src     = 2'b00;
    alu_control = ALU_ADD;
    case (state_q)
      FETCH: begin
        state_d    = DECODE;
        irw_raw    = 1'b1;
        pcw_raw    = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = i_bit ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        reg_src   = {(op == 2'b01) && !s_bit, op == 2'b10};
      end
      MEMADR: begin
        state_d   = s_bit ? MEMRD : MEMWR;
        alu_src_b = 2'b01;
        imm_src   = 2'b01;
      end
      MEMRD: begin
        state_d = MEMWB;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        regw_raw   = cond_ex;
      end
      MEMWR: begin
        adr_src  = 1'b1;
        memw_raw = cond_ex;
      end
      EXECR: begin
        state_d     = ALUWB;
        alu_control = dp_alu;
      end
      EXECI: begin
        state_d     = ALUWB;
        alu_src_b   = 2'b01;
        alu_control = dp_alu;
      end
      ALUWB: begin
        if (rd == 4'd15) pcw_raw  = cond_ex;
        else             regw_raw = cond_ex & dp_wb;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        imm_src    = 2'b10;
        result_src = 2'b10;
        pcw_raw    = cond_ex;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset kills strobes combinationally so an in-flight write aborts at once
  assign pc_write  = pcw_raw  & ~reset;
  assign mem_write = memw_raw & ~reset;
  assign reg_write = regw_raw & ~reset;
  assign ir_write  = irw_raw  & ~reset;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: directed instruction table, reset corner
// cases, and random instruction streams against an instruction-level model.
module tb_arm_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond, rd, alu_flags;
  logic [1:0] op;
  logic [5:0] funct;
  logic       pc_write, mem_write, reg_write, ir_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src;
  logic [2:0] alu_control;
  logic [3:0] flags;

  arm_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .pc_write(pc_write), .mem_write(mem_write),
    .reg_write(reg_write), .ir_write(ir_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .reg_src(reg_src), .alu_control(alu_control), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, memw, regw, irw, adr;
    logic [1:0] asa, asb, rs, is, rsrc;
    logic [2:0] aluc;
    logic [3:0] fl;
  } out_t;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd, af;
    int         cyc;
    logic [3:0] fl;
    logic       rw, mw, pw;
    logic [2:0] ac;
  } vec_t;

  int tests = 0, fails = 0;
  logic [3:0] mf;
  out_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    tests++;
    if (act !== exv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exv);
    end
  endtask

  function automatic out_t sample();
    return {pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a, alu_src_b,
            result_src, imm_src, reg_src, alu_control, flags};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;          4'd1:  return !z;
      4'd2:  return cy;         4'd3:  return !cy;
      4'd4:  return n;          4'd5:  return !n;
      4'd6:  return v;          4'd7:  return !v;
      4'd8:  return cy && !z;   4'd9:  return !cy || z;
      4'd10: return n == v;     4'd11: return n != v;
      4'd12: return !z && n == v;
      4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic out_t base();
    out_t o = '0;
    o.fl = mf;
    return o;
  endfunction

  // Expected per-cycle outputs of one whole instruction; updates model flags
  task automatic model_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] d, input logic [3:0] af);
    out_t r;
    logic ok, s;
    logic [3:0] k;
    logic [2:0] alu;
    logic writes, logical, is_cmp;
    s = f[0];
    k = f[4:1];
    exp_q.delete();
    r = base(); r.irw = 1; r.pcw = 1; r.asa = 2'b01; r.asb = 2'b10; r.rs = 2'b10;
    exp_q.push_back(r);
    r = base(); r.asa = 2'b01; r.asb = 2'b10;
    r.rsrc = {o == 2'b01 && !s, o == 2'b10};
    exp_q.push_back(r);
    ok = cond_ok(c, mf);
    if (o == 2'b00) begin
      alu = 3'b000; writes = 0; logical = 0; is_cmp = 0;
      if (k == 4'b0100) writes = 1;
      else if (k == 4'b0010) begin alu = 3'b001; writes = 1; end
      else if (k == 4'b1010) begin alu = 3'b001; is_cmp = 1; end
      else if (k == 4'b0000) begin alu = 3'b010; writes = 1; logical = 1; end
      else if (k == 4'b1100) begin alu = 3'b011; writes = 1; logical = 1; end
      else if (k == 4'b1101) begin alu = 3'b100; writes = 1; logical = 1; end
      r = base(); r.asb = f[5] ? 2'b01 : 2'b00; r.aluc = alu;
      exp_q.push_back(r);
      if (ok && (s || is_cmp)) mf = logical ? {af[3:2], mf[1:0]} : af;
      ok = cond_ok(c, mf);
      r = base();
      if (d == 4'd15) r.pcw = ok;
      else            r.regw = ok && writes;
      exp_q.push_back(r);
    end else if (o == 2'b01) begin
      r = base(); r.asb = 2'b01; r.is = 2'b01;
      exp_q.push_back(r);
      if (s) begin
        r = base(); r.adr = 1; exp_q.push_back(r);
        r = base(); r.rs = 2'b01; r.regw = ok; exp_q.push_back(r);
      end else begin
        r = base(); r.adr = 1; r.memw = ok; exp_q.push_back(r);
      end
    end else if (o == 2'b10) begin
      r = base(); r.asb = 2'b01; r.is = 2'b10; r.rs = 2'b10; r.pcw = ok;
      exp_q.push_back(r);
    end
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{4'he, 2'b00, 6'b001000, 4'd1,  4'b1111, 4, 4'b0000, 1, 0, 0, 3'b000}; // ADD
    tbl[1]  = '{4'he, 2'b00, 6'b010101, 4'd0,  4'b0100, 4, 4'b0100, 0, 0, 0, 3'b001}; // CMP
    tbl[2]  = '{4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 3, 4'b0100, 0, 0, 1, 3'b000}; // BEQ
    tbl[3]  = '{4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000, 3, 4'b0100, 0, 0, 0, 3'b000}; // BNE
    tbl[4]  = '{4'he, 2'b00, 6'b001001, 4'd2,  4'b0011, 4, 4'b0011, 1, 0, 0, 3'b000}; // ADDS
    tbl[5]  = '{4'he, 2'b00, 6'b000001, 4'd4,  4'b1011, 4, 4'b1011, 1, 0, 0, 3'b010}; // ANDS
    tbl[6]  = '{4'he, 2'b00, 6'b111001, 4'd5,  4'b0100, 4, 4'b0111, 1, 0, 0, 3'b011}; // ORRS imm
    tbl[7]  = '{4'he, 2'b01, 6'b011001, 4'd3,  4'b0000, 5, 4'b0111, 1, 0, 0, 3'b000}; // LDR
    tbl[8]  = '{4'he, 2'b01, 6'b011000, 4'd3,  4'b0000, 4, 4'b0111, 0, 1, 0, 3'b000}; // STR
    tbl[9]  = '{4'he, 2'b00, 6'b011010, 4'd15, 4'b0000, 4, 4'b0111, 0, 0, 1, 3'b100}; // MOV pc
    tbl[10] = '{4'h1, 2'b00, 6'b001001, 4'd6,  4'b1000, 4, 4'b0111, 0, 0, 0, 3'b000}; // ADDSNE fails
    tbl[11] = '{4'hf, 2'b01, 6'b011001, 4'd3,  4'b0000, 5, 4'b0111, 0, 0, 0, 3'b000}; // LDR never
    tbl[12] = '{4'he, 2'b11, 6'b000000, 4'd0,  4'b0000, 2, 4'b0111, 0, 0, 0, 3'b000}; // NOP

    reset = 1'b1; cond = 4'he; op = 2'b00; funct = '0; rd = '0; alu_flags = '0;
    #1;
    chk("reset_outputs", sample(), {5'b0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0000});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;

    foreach (tbl[i]) begin
      int   cycles;
      logic sw_r, sw_m, sw_p;
      logic [2:0] ac2;
      cond = tbl[i].cond; op = tbl[i].op; funct = tbl[i].funct;
      rd = tbl[i].rd; alu_flags = tbl[i].af;
      cycles = 0; sw_r = 0; sw_m = 0; sw_p = 0; ac2 = 3'b000;
      for (int c = 0; c < 10; c++) begin
        if (c > 0 && ir_write) break;
        sw_r |= reg_write;
        sw_m |= mem_write;
        if (c > 0) sw_p |= pc_write;
        if (c == 2) ac2 = alu_control;
        cycles++;
        @(posedge clk); #1;
      end
      chk($sformatf("tbl%0d_latency", i), cycles, tbl[i].cyc);
      chk($sformatf("tbl%0d_flags", i), flags, tbl[i].fl);
      chk($sformatf("tbl%0d_reg_write", i), sw_r, tbl[i].rw);
      chk($sformatf("tbl%0d_mem_write", i), sw_m, tbl[i].mw);
      chk($sformatf("tbl%0d_pc_write", i), sw_p, tbl[i].pw);
      chk($sformatf("tbl%0d_alu_control", i), ac2, tbl[i].ac);
    end

    // Reset in the middle of a store's MEMWR
    cond = 4'he; op = 2'b01; funct = 6'b011000; rd = 4'd1;
    repeat (3) begin @(posedge clk); #1; end
    chk("memwr_before_reset", mem_write, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("memwr_async_drop", {pc_write, mem_write, reg_write, ir_write}, 4'b0000);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    chk("post_reset_flags", flags, 4'b0000);
    chk("post_reset_fetch", {ir_write, pc_write}, 2'b11);
    @(posedge clk); #1;
    chk("post_reset_decode", {ir_write, reg_src, alu_src_b}, {1'b0, 2'b10, 2'b10});
    op = 2'b11;
    @(posedge clk); #1;

    // Random instruction stream against the model
    mf = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      cond = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      funct = 6'($urandom_range(0, 63));
      rd = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      alu_flags = 4'($urandom_range(0, 15));
      model_instr(cond, op, funct, rd, alu_flags);
      foreach (exp_q[j]) begin
        chk($sformatf("rnd%0d_cyc%0d", n, j), sample(), exp_q[j]);
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
